// File: rtl/pong_pkg.sv
// Shared encodings for the pong match sequencer
// and the display blocks that read its state.
package pong_pkg;

  localparam int STATE_W       = 3;
  localparam int WINNER_W      = 2;
  localparam int DELAY_W       = 8;
  localparam int SCORE_W_DEF   = 4;
  localparam int WIN_SCORE_DEF = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_SCORED = 3'd4,
    ST_OVER   = 3'd5
  } state_e;

  localparam logic [WINNER_W-1:0] WIN_NONE = 2'b00;
  localparam logic [WINNER_W-1:0] WIN_P1   = 2'b01;
  localparam logic [WINNER_W-1:0] WIN_P2   = 2'b10;

  function automatic logic ball_held(state_e s);
    return !(s == ST_PLAY || s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Buttons, ball datapath flags and score/state
// outputs of the match sequencer.
interface pong_match_ctrl_if
  import pong_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
);

  logic                start_btn;
  logic                pause_btn;
  logic                point_1;
  logic                point_2;
  logic                ball_rst;
  logic                ball_step;
  logic [SCORE_W-1:0]  score_1;
  logic [SCORE_W-1:0]  score_2;
  logic [WINNER_W-1:0] winner;
  logic [STATE_W-1:0]  state;

  modport master (
    input  start_btn,
    input  pause_btn,
    input  point_1,
    input  point_2,
    output ball_rst,
    output ball_step,
    output score_1,
    output score_2,
    output winner,
    output state
  );

  modport slave (
    output start_btn,
    output pause_btn,
    output point_1,
    output point_2,
    input  ball_rst,
    input  ball_step,
    input  score_1,
    input  score_2,
    input  winner,
    input  state
  );

endinterface

// File: rtl/tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled,
// tick_o is high in the cycle the count wraps.
module tick_gen #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap   = (cnt_q == LAST);
  assign tick_o = en_i & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve delay, play pacing,
// scoring, pause and game-over.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int TICK_DIV    = 250000,
  parameter int SERVE_DELAY = 100,
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int SCORE_W     = SCORE_W_DEF
) (
  input  logic clk,
  input  logic reset,
  pong_match_ctrl_if.master bus
);

  localparam logic [DELAY_W-1:0] SERVE_LAST =
    DELAY_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_S =
    SCORE_W'(WIN_SCORE);

  state_e              state_q, state_d;
  logic                ball_rst_q, ball_rst_d;
  logic                ball_step_q, ball_step_d;
  logic [SCORE_W-1:0]  score_1_q, score_1_d;
  logic [SCORE_W-1:0]  score_2_q, score_2_d;
  logic [WINNER_W-1:0] winner_q, winner_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic                start_prev_q, pause_prev_q;

  logic start_e, pause_e;
  logic tick, tick_en, tick_clr;

  assign start_e = bus.start_btn & ~start_prev_q;
  assign pause_e = bus.pause_btn & ~pause_prev_q;

  // Frozen (neither enabled nor cleared) in PAUSE.
  assign tick_en  = (state_q == ST_SERVE) ||
                    (state_q == ST_PLAY);
  assign tick_clr = (state_q == ST_IDLE) ||
                    (state_q == ST_SCORED) ||
                    (state_q == ST_OVER);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (tick_en),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    score_1_d = score_1_q;
    score_2_d = score_2_q;
    winner_d  = winner_q;
    delay_d   = delay_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_e) begin
          score_1_d = '0;
          score_2_d = '0;
          winner_d  = WIN_NONE;
          delay_d   = '0;
          state_d   = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          if (delay_q == SERVE_LAST)
            state_d = ST_PLAY;
          else
            delay_d = delay_q + DELAY_W'(1);
        end
      end
      ST_PLAY: begin
        if (bus.point_1) begin
          score_1_d = score_1_q + SCORE_W'(1);
          state_d   = ST_SCORED;
        end else if (bus.point_2) begin
          score_2_d = score_2_q + SCORE_W'(1);
          state_d   = ST_SCORED;
        end else if (pause_e) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_e) state_d = ST_PLAY;
      end
      ST_SCORED: begin
        if (score_1_q == WIN_S) begin
          winner_d = WIN_P1;
          state_d  = ST_OVER;
        end else if (score_2_q == WIN_S) begin
          winner_d = WIN_P2;
          state_d  = ST_OVER;
        end else begin
          delay_d = '0;
          state_d = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered off the next state so both outputs
    // switch together with the state code.
    ball_rst_d  = ball_held(state_d);
    ball_step_d = tick &&
                  (state_q == ST_PLAY) &&
                  (state_d == ST_PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ball_rst_q   <= 1'b1;
      ball_step_q  <= 1'b0;
      score_1_q    <= '0;
      score_2_q    <= '0;
      winner_q     <= WIN_NONE;
      delay_q      <= '0;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ball_rst_q   <= ball_rst_d;
      ball_step_q  <= ball_step_d;
      score_1_q    <= score_1_d;
      score_2_q    <= score_2_d;
      winner_q     <= winner_d;
      delay_q      <= delay_d;
      start_prev_q <= bus.start_btn;
      pause_prev_q <= bus.pause_btn;
    end
  end

  assign bus.state     = state_q;
  assign bus.ball_rst  = ball_rst_q;
  assign bus.ball_step = ball_step_q;
  assign bus.score_1   = score_1_q;
  assign bus.score_2   = score_2_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Match sequencer bench: predicted output changes are
// queued on stimulus and popped as the DUT changes.
module tb_pong_match_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pong_match_ctrl_if #(.SCORE_W(4)) bus ();

  pong_match_ctrl #(
    .TICK_DIV    (4),
    .SERVE_DELAY (3),
    .WIN_SCORE   (2),
    .SCORE_W     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [13:0] sb[$];
  logic [13:0] prev_t;
  bit          mon_en = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h",
               tag, act, exp);
    end
  endtask

  function automatic logic [13:0] tup(
    input logic [2:0] st, input logic r,
    input logic [3:0] a, input logic [3:0] b,
    input logic [1:0] w);
    return {st, r, a, b, w};
  endfunction

  function automatic logic [13:0] cur_t();
    return {bus.state, bus.ball_rst,
            bus.score_1, bus.score_2, bus.winner};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st,
                            input int max,
                            output int n);
    n = 0;
    while (bus.state !== st && n < max) begin
      step();
      n++;
    end
    if (bus.state !== st)
      chk("timeout", 32'(bus.state), 32'(st));
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [13:0] t, e;
    if (mon_en) begin
      t = cur_t();
      if (bus.ball_step)
        chk("step_rst", 32'(bus.ball_rst), 32'd0);
      if (t !== prev_t) begin
        if (sb.size() == 0) begin
          chk("unexp", 32'(t), 32'(prev_t));
        end else begin
          e = sb.pop_front();
          chk("seq", 32'(t), 32'(e));
        end
        prev_t = t;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=done");
    $fatal(1);
  end

  initial begin
    int n, t_srv, cnt, first;
    logic [11:0] v;
    reset = 1'b1;
    bus.start_btn = 1'b0;
    bus.pause_btn = 1'b0;
    bus.point_1   = 1'b0;
    bus.point_2   = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (20) step();
    chk("idle_state", 32'(bus.state), 32'd0);
    chk("idle_brst", 32'(bus.ball_rst), 32'd1);
    chk("idle_step", 32'(bus.ball_step), 32'd0);
    chk("idle_sc",
        32'({bus.score_1, bus.score_2, bus.winner}),
        32'd0);
    prev_t = cur_t();
    mon_en = 1'b1;

    // Held start: one serve, then play after 3 ticks.
    sb.push_back(tup(3'd1, 1'b1, 4'd0, 4'd0, 2'd0));
    sb.push_back(tup(3'd2, 1'b0, 4'd0, 4'd0, 2'd0));
    bus.start_btn = 1'b1;
    t_srv = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.state === 3'd1 && t_srv == 0)
        t_srv = i;
    end
    bus.start_btn = 1'b0;
    chk("serve_lat", 32'(t_srv), 32'd1);
    wait_state(3'd2, 20, n);
    chk("serve_len", 32'(10 + n - t_srv), 32'd12);
    chk("play_brst", 32'(bus.ball_rst), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      v[i] = bus.ball_step;
    end
    chk("step_pat", 32'(v), 32'h888);

    // Player 2 scores; points ignored while serving.
    sb.push_back(tup(3'd4, 1'b1, 4'd0, 4'd1, 2'd0));
    sb.push_back(tup(3'd1, 1'b1, 4'd0, 4'd1, 2'd0));
    sb.push_back(tup(3'd2, 1'b0, 4'd0, 4'd1, 2'd0));
    bus.point_2 = 1'b1;
    step();
    bus.point_2 = 1'b0;
    chk("p2_scored", 32'(bus.state), 32'd4);
    chk("p2_score", 32'(bus.score_2), 32'd1);
    step();
    chk("scored_1clk", 32'(bus.state), 32'd1);
    bus.point_1 = 1'b1;
    step();
    bus.point_1 = 1'b0;
    bus.point_2 = 1'b1;
    step();
    bus.point_2 = 1'b0;
    chk("serve_pt",
        32'({bus.score_1, bus.score_2}), 32'h01);
    wait_state(3'd2, 20, n);
    chk("serve2_len", 32'(n + 2), 32'd12);

    // Both points at once: player 1 only.
    sb.push_back(tup(3'd4, 1'b1, 4'd1, 4'd1, 2'd0));
    sb.push_back(tup(3'd1, 1'b1, 4'd1, 4'd1, 2'd0));
    sb.push_back(tup(3'd2, 1'b0, 4'd1, 4'd1, 2'd0));
    bus.point_1 = 1'b1;
    bus.point_2 = 1'b1;
    step();
    bus.point_1 = 1'b0;
    bus.point_2 = 1'b0;
    chk("both_pts",
        32'({bus.score_1, bus.score_2}), 32'h11);
    wait_state(3'd2, 20, n);
    chk("serve3_len", 32'(n), 32'd13);

    // Pause with prescaler at 2.
    step();
    step();
    sb.push_back(tup(3'd3, 1'b0, 4'd1, 4'd1, 2'd0));
    bus.pause_btn = 1'b1;
    step();
    bus.pause_btn = 1'b0;
    chk("paused", 32'(bus.state), 32'd3);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      bus.start_btn = (i == 10);
      bus.point_1   = (i == 20);
      step();
      cnt += int'(bus.ball_step);
    end
    bus.start_btn = 1'b0;
    bus.point_1   = 1'b0;
    chk("pause_nostep", 32'(cnt), 32'd0);
    chk("pause_hold", 32'(bus.state), 32'd3);
    sb.push_back(tup(3'd2, 1'b0, 4'd1, 4'd1, 2'd0));
    bus.pause_btn = 1'b1;
    first = 0;
    for (int k = 1; k <= 10 && first == 0; k++) begin
      step();
      bus.pause_btn = 1'b0;
      if (bus.ball_step) first = k;
    end
    chk("resume_step", 32'(first), 32'd2);

    // Point beats pause; second point wins the match.
    sb.push_back(tup(3'd4, 1'b1, 4'd2, 4'd1, 2'd0));
    sb.push_back(tup(3'd5, 1'b1, 4'd2, 4'd1, 2'd1));
    bus.point_1   = 1'b1;
    bus.pause_btn = 1'b1;
    step();
    bus.point_1   = 1'b0;
    bus.pause_btn = 1'b0;
    chk("pt_vs_pause", 32'(bus.state), 32'd4);
    step();
    chk("over_state", 32'(bus.state), 32'd5);
    chk("winner", 32'(bus.winner), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.pause_btn = (i == 3);
      bus.point_2   = (i == 5);
      step();
    end
    bus.pause_btn = 1'b0;
    bus.point_2   = 1'b0;
    chk("over_hold",
        32'({bus.state, bus.score_1,
             bus.score_2, bus.winner}),
        32'({3'd5, 4'd2, 4'd1, 2'd1}));

    // Restart from OVER, score, then reset mid-play.
    sb.push_back(tup(3'd1, 1'b1, 4'd0, 4'd0, 2'd0));
    sb.push_back(tup(3'd2, 1'b0, 4'd0, 4'd0, 2'd0));
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
    chk("restart",
        32'({bus.state, bus.score_1,
             bus.score_2, bus.winner}),
        32'({3'd1, 10'd0}));
    wait_state(3'd2, 20, n);
    sb.push_back(tup(3'd4, 1'b1, 4'd1, 4'd0, 2'd0));
    sb.push_back(tup(3'd1, 1'b1, 4'd1, 4'd0, 2'd0));
    sb.push_back(tup(3'd2, 1'b0, 4'd1, 4'd0, 2'd0));
    bus.point_1 = 1'b1;
    step();
    bus.point_1 = 1'b0;
    wait_state(3'd2, 20, n);
    repeat (5) step();
    sb.push_back(tup(3'd0, 1'b1, 4'd0, 4'd0, 2'd0));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_state", 32'(bus.state), 32'd0);
    chk("mr_brst", 32'(bus.ball_rst), 32'd1);
    chk("mr_step", 32'(bus.ball_step), 32'd0);
    chk("mr_s1", 32'(bus.score_1), 32'd0);
    chk("mr_win", 32'(bus.winner), 32'd0);
    repeat (5) step();
    chk("sb_left", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
